// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seg_pkg;

    localparam int unsigned DIG_N  = 4;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned DATA_W = DIG_N * NIB_W;
    localparam int unsigned SEG_W  = 7;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_e;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [DIG_N-1:0] AN_OFF    = 4'b1111;

    localparam logic [SEG_W-1:0] GLYPH_0 = 7'h40;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'h24;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'h30;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'h19;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'h12;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'h02;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'h78;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'h00;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'h10;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'h08;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'h03;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'h46;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'h21;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'h0E;

    // Value shown on the display: four nibbles plus per-digit decimal points
    typedef struct packed {
        logic [DIG_N-1:0]  dp;
        logic [DATA_W-1:0] digits;
    } disp_t;

    // True when digit k (k>0) and every more significant nibble are zero
    function automatic logic lz_suppress(input logic [DATA_W-1:0] d, input logic [1:0] k);
        logic res;
        res = 1'b0;
        case (k)
            2'd3:    res = (d[15:12] == 4'h0);
            2'd2:    res = (d[15:8]  == 8'h00);
            2'd1:    res = (d[15:4]  == 12'h000);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side load/control signals and display-side drive signals of the scan controller.
interface seg_scan_ctrl_if;
    import seg_pkg::*;

    logic                enable;
    logic                load;
    logic [DATA_W-1:0]   data_in;
    logic [DIG_N-1:0]    dp_in;
    logic                lz_blank;
    logic [DIG_N-1:0]    an;
    logic [SEG_W-1:0]    seg;
    logic                dp;
    logic                pending;
    logic                frame_done;

    modport master (
        output enable, load, data_in, dp_in, lz_blank,
        input  an, seg, dp, pending, frame_done
    );

    modport slave (
        input  enable, load, data_in, dp_in, lz_blank,
        output an, seg, dp, pending, frame_done
    );

endinterface

// File: rtl/seg_decode.sv
// Hex nibble to active-low seven-segment glyph, purely combinational.
module seg_decode
    import seg_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = GLYPH_F;
        case (nib_i)
            4'h0:    seg_c = GLYPH_0;
            4'h1:    seg_c = GLYPH_1;
            4'h2:    seg_c = GLYPH_2;
            4'h3:    seg_c = GLYPH_3;
            4'h4:    seg_c = GLYPH_4;
            4'h5:    seg_c = GLYPH_5;
            4'h6:    seg_c = GLYPH_6;
            4'h7:    seg_c = GLYPH_7;
            4'h8:    seg_c = GLYPH_8;
            4'h9:    seg_c = GLYPH_9;
            4'hA:    seg_c = GLYPH_A;
            4'hB:    seg_c = GLYPH_B;
            4'hC:    seg_c = GLYPH_C;
            4'hD:    seg_c = GLYPH_D;
            4'hE:    seg_c = GLYPH_E;
            default: seg_c = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with blanking gaps and
// frame-synchronous double-buffered display updates.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic          in_clk,
    input  logic          reset,
    seg_scan_ctrl_if.slave bus
);

    localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] LAST_DRIVE = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK_CYCLES - 1);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    disp_t             disp_q, disp_d;
    disp_t             shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic [DIG_N-1:0]  an_q, an_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              frame_done_q, frame_done_d;

    logic              boundary_c;
    logic [NIB_W-1:0]  nib_c;
    logic [SEG_W-1:0]  glyph_c;

    // Decode the nibble that will be on the bus in the next cycle
    assign nib_c = disp_d.digits[{idx_d, 2'b00} +: NIB_W];

    seg_decode u_decode (
        .nib_i (nib_c),
        .seg_c (glyph_c)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        disp_d       = disp_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        an_d         = AN_OFF;
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;
        frame_done_d = 1'b0;

        boundary_c = (state_q == DRIVE) && (idx_q == 2'd3) && (cnt_q == LAST_DRIVE);

        // Scan sequencing
        if (!bus.enable) begin
            state_d = BLANK;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                BLANK: begin
                    if (cnt_q == LAST_BLANK) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (cnt_q == LAST_DRIVE) begin
                        state_d = BLANK;
                        idx_d   = idx_q + 2'd1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end
            endcase
        end

        // Display updates land only between frames or while dark, so a frame never tears
        if (bus.load) begin
            if (boundary_c || !bus.enable) begin
                disp_d    = '{dp: bus.dp_in, digits: bus.data_in};
                pending_d = 1'b0;
            end else begin
                shadow_d  = '{dp: bus.dp_in, digits: bus.data_in};
                pending_d = 1'b1;
            end
        end else if (pending_q && (boundary_c || !bus.enable)) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end

        if (state_d == DRIVE) begin
            an_d         = ~(4'b0001 << idx_d);
            seg_d        = (bus.lz_blank && lz_suppress(disp_d.digits, idx_d)) ? SEG_BLANK : glyph_c;
            dp_d         = ~disp_d.dp[idx_d];
            frame_done_d = (idx_d == 2'd3) && (cnt_d == LAST_DRIVE);
        end
    end

    always_ff @(posedge in_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BLANK;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            disp_q       <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            disp_q       <= disp_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=4, BLANK_CYCLES=2 (24-cycle frame).
module tb_seg_scan_ctrl;

    logic clk;
    logic rst_n;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .SCAN_DIV     (4),
        .BLANK_CYCLES (2)
    ) dut (
        .in_clk (clk),
        .reset  (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned rep;
        logic        en;
        logic        ld;
        logic [15:0] data;
        logic [3:0]  dpi;
        logic        lz;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        pend;
        logic        fd;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    task automatic add(input int unsigned rep, input logic en, input logic ld,
                       input logic [15:0] data, input logic [3:0] dpi, input logic lz,
                       input logic [3:0] an, input logic [6:0] seg, input logic dp,
                       input logic pend, input logic fd, input string name);
        vec_t v;
        v.rep = rep; v.en = en; v.ld = ld; v.data = data; v.dpi = dpi; v.lz = lz;
        v.an = an; v.seg = seg; v.dp = dp; v.pend = pend; v.fd = fd; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] an, input logic [6:0] seg,
                         input logic dp, input logic pend, input logic fd);
        n_cmp++;
        if ({bus.an, bus.seg, bus.dp, bus.pending, bus.frame_done} !== {an, seg, dp, pend, fd}) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got an=%b seg=%h dp=%b pend=%b fd=%b want an=%b seg=%h dp=%b pend=%b fd=%b",
                     name, cyc, bus.an, bus.seg, bus.dp, bus.pending, bus.frame_done,
                     an, seg, dp, pend, fd);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.enable   = 1'b1;
        bus.load     = 1'b0;
        bus.data_in  = 16'h0000;
        bus.dp_in    = 4'h0;
        bus.lz_blank = 1'b0;

        // Frame 1: display zero; load 12AF mid-frame
        add(2,1,0,16'h0,4'h0,0, 4'hF,7'h7F,1,0,0,"f1_blank0");
        add(4,1,0,16'h0,4'h0,0, 4'hE,7'h40,1,0,0,"f1_d0");
        add(2,1,0,16'h0,4'h0,0, 4'hF,7'h7F,1,0,0,"f1_blank1");
        add(1,1,0,16'h0,4'h0,0, 4'hD,7'h40,1,0,0,"f1_d1");
        add(1,1,1,16'h12AF,4'b0100,0, 4'hD,7'h40,1,0,0,"f1_load");
        add(2,1,0,16'h0,4'h0,0, 4'hD,7'h40,1,1,0,"f1_d1_pend");
        add(2,1,0,16'h0,4'h0,0, 4'hF,7'h7F,1,1,0,"f1_blank2");
        add(4,1,0,16'h0,4'h0,0, 4'hB,7'h40,1,1,0,"f1_d2");
        add(2,1,0,16'h0,4'h0,0, 4'hF,7'h7F,1,1,0,"f1_blank3");
        add(3,1,0,16'h0,4'h0,0, 4'h7,7'h40,1,1,0,"f1_d3");
        add(1,1,0,16'h0,4'h0,0, 4'h7,7'h40,1,1,1,"f1_boundary");
        // Frame 2: 12AF, dp on digit 2
        add(2,1,0,16'h0,4'h0,0, 4'hF,7'h7F,1,0,0,"f2_blank0");
        add(4,1,0,16'h0,4'h0,0, 4'hE,7'h0E,1,0,0,"f2_d0_F");
        add(2,1,0,16'h0,4'h0,0, 4'hF,7'h7F,1,0,0,"f2_blank1");
        add(4,1,0,16'h0,4'h0,0, 4'hD,7'h08,1,0,0,"f2_d1_A");
        add(2,1,0,16'h0,4'h0,0, 4'hF,7'h7F,1,0,0,"f2_blank2");
        add(4,1,0,16'h0,4'h0,0, 4'hB,7'h24,0,0,0,"f2_d2_2");
        add(2,1,0,16'h0,4'h0,0, 4'hF,7'h7F,1,0,0,"f2_blank3");
        add(3,1,0,16'h0,4'h0,0, 4'h7,7'h79,1,0,0,"f2_d3_1");
        add(1,1,0,16'h0,4'h0,0, 4'h7,7'h79,1,0,1,"f2_boundary");
        // Frame 3: two loads, second overwrites the first; lz_blank on
        add(2,1,0,16'h0,4'h0,1, 4'hF,7'h7F,1,0,0,"f3_blank0");
        add(1,1,1,16'h1111,4'hF,1, 4'hE,7'h0E,1,0,0,"f3_load1");
        add(3,1,0,16'h0,4'h0,1, 4'hE,7'h0E,1,1,0,"f3_d0_pend");
        add(2,1,0,16'h0,4'h0,1, 4'hF,7'h7F,1,1,0,"f3_blank1");
        add(1,1,1,16'h0008,4'h0,1, 4'hD,7'h08,1,1,0,"f3_load2");
        add(3,1,0,16'h0,4'h0,1, 4'hD,7'h08,1,1,0,"f3_d1");
        add(2,1,0,16'h0,4'h0,1, 4'hF,7'h7F,1,1,0,"f3_blank2");
        add(4,1,0,16'h0,4'h0,1, 4'hB,7'h24,0,1,0,"f3_d2");
        add(2,1,0,16'h0,4'h0,1, 4'hF,7'h7F,1,1,0,"f3_blank3");
        add(3,1,0,16'h0,4'h0,1, 4'h7,7'h79,1,1,0,"f3_d3");
        add(1,1,0,16'h0,4'h0,1, 4'h7,7'h79,1,1,1,"f3_boundary");
        // Frame 4: 0008 with leading zeros blanked; load on the boundary cycle
        add(2,1,0,16'h0,4'h0,1, 4'hF,7'h7F,1,0,0,"f4_blank0");
        add(4,1,0,16'h0,4'h0,1, 4'hE,7'h00,1,0,0,"f4_d0_8");
        add(2,1,0,16'h0,4'h0,1, 4'hF,7'h7F,1,0,0,"f4_blank1");
        add(4,1,0,16'h0,4'h0,1, 4'hD,7'h7F,1,0,0,"f4_d1_lz");
        add(2,1,0,16'h0,4'h0,1, 4'hF,7'h7F,1,0,0,"f4_blank2");
        add(4,1,0,16'h0,4'h0,1, 4'hB,7'h7F,1,0,0,"f4_d2_lz");
        add(2,1,0,16'h0,4'h0,1, 4'hF,7'h7F,1,0,0,"f4_blank3");
        add(3,1,0,16'h0,4'h0,1, 4'h7,7'h7F,1,0,0,"f4_d3_lz");
        add(1,1,1,16'h0C00,4'h0,1, 4'h7,7'h7F,1,0,1,"f4_boundary_load");
        // Frame 5: 0C00, inner zero not suppressed, leading zero is
        add(2,1,0,16'h0,4'h0,1, 4'hF,7'h7F,1,0,0,"f5_blank0");
        add(4,1,0,16'h0,4'h0,1, 4'hE,7'h40,1,0,0,"f5_d0");
        add(2,1,0,16'h0,4'h0,1, 4'hF,7'h7F,1,0,0,"f5_blank1");
        add(4,1,0,16'h0,4'h0,1, 4'hD,7'h40,1,0,0,"f5_d1_inner0");
        add(2,1,0,16'h0,4'h0,1, 4'hF,7'h7F,1,0,0,"f5_blank2");
        add(4,1,0,16'h0,4'h0,1, 4'hB,7'h46,1,0,0,"f5_d2_C");
        add(2,1,0,16'h0,4'h0,1, 4'hF,7'h7F,1,0,0,"f5_blank3");
        add(3,1,0,16'h0,4'h0,1, 4'h7,7'h7F,1,0,0,"f5_d3_lz");
        add(1,1,0,16'h0,4'h0,1, 4'h7,7'h7F,1,0,1,"f5_boundary");
        // Enable dropped mid-DRIVE with a pending value, then restored
        add(2,1,0,16'h0,4'h0,0, 4'hF,7'h7F,1,0,0,"e_blank0");
        add(1,1,1,16'h4444,4'h0,0, 4'hE,7'h40,1,0,0,"e_load");
        add(1,0,0,16'h0,4'h0,0, 4'hE,7'h40,1,1,0,"e_disable");
        add(1,1,0,16'h0,4'h0,0, 4'hF,7'h7F,1,0,0,"e_dark");
        add(1,1,0,16'h0,4'h0,0, 4'hF,7'h7F,1,0,0,"e_restart_blank");
        add(4,1,0,16'h0,4'h0,0, 4'hE,7'h19,1,0,0,"e_d0_new");
        add(2,1,0,16'h0,4'h0,0, 4'hF,7'h7F,1,0,0,"e_blank1");
        add(1,1,0,16'h0,4'h0,0, 4'hD,7'h19,1,0,0,"e_d1");
        add(1,1,1,16'h9999,4'h0,0, 4'hD,7'h19,1,0,0,"e_load2");
        add(2,1,0,16'h0,4'h0,0, 4'hD,7'h19,1,1,0,"e_d1_pend");
        add(2,1,0,16'h0,4'h0,0, 4'hF,7'h7F,1,1,0,"e_blank2");
        add(1,1,0,16'h0,4'h0,0, 4'hB,7'h19,1,1,0,"e_d2");

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Inputs for cycle k are driven just after edge k; outputs sampled at the following negedge
        foreach (vecs[i]) begin
            for (int r = 0; r < int'(vecs[i].rep); r++) begin
                bus.enable   = vecs[i].en;
                bus.load     = vecs[i].ld;
                bus.data_in  = vecs[i].data;
                bus.dp_in    = vecs[i].dpi;
                bus.lz_blank = vecs[i].lz;
                @(negedge clk);
                check(vecs[i].name, vecs[i].an, vecs[i].seg, vecs[i].dp, vecs[i].pend, vecs[i].fd);
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        bus.load   = 1'b0;
        bus.enable = 1'b1;

        // Reset pulse in the middle of digit 2 with a value pending
        @(negedge clk);
        check("pre_reset_d2", 4'hB, 7'h19, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("reset_async", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("post_reset_blank", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
            @(posedge clk);
            #1 cyc++;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_reset_d0_zero", 4'hE, 7'h40, 1'b1, 1'b0, 1'b0);
            @(posedge clk);
            #1 cyc++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
